// File: rtl/wb_regfile_pkg.sv
// Shared types and helpers for the writeback stage / register file slice.
// DATA_W sizes the pending-entry payload and must match the top-level DW.
package wb_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int TAG_W      = 64;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     next_pc;
    logic [TAG_W-1:0]      tag;
  } pend_entry_t;

  // Drops address bits above $clog2(nregs); the result stays REG_ADDR_W wide.
  function automatic logic [REG_ADDR_W-1:0] reg_index(input logic [REG_ADDR_W-1:0] addr,
                                                      input int nregs);
    return addr & REG_ADDR_W'(nregs - 1);
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// Architectural GPR storage: async clear, one write port, NRP combinational
// read ports; index 0 has no storage, so it reads 0 and ignores writes.
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int NRP   = 2,
  parameter int DW    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_we,
  input  logic [REG_ADDR_W-1:0]     i_waddr,
  input  logic [DW-1:0]             i_wdata,
  input  logic [NRP*REG_ADDR_W-1:0] i_raddr,
  output logic [NRP*DW-1:0]         o_rdata
);

  logic [DW-1:0]         r_rf [1:NREGS-1];
  logic [REG_ADDR_W-1:0] w_widx;

  assign w_widx = reg_index(i_waddr, NREGS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 1; j < NREGS; j++) r_rf[j] <= '0;
    end else if (i_we) begin
      for (int j = 1; j < NREGS; j++)
        if (w_widx == REG_ADDR_W'(j)) r_rf[j] <= i_wdata;
    end
  end

  // Compare-select read mux; index 0 never matches, leaving the zero default.
  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NRP; p++)
      for (int j = 1; j < NREGS; j++)
        if (reg_index(i_raddr[p*REG_ADDR_W +: REG_ADDR_W], NREGS) == REG_ADDR_W'(j))
          o_rdata[p*DW +: DW] = r_rf[j];
  end

endmodule

// File: rtl/wb_regfile_pipe.sv
// Writeback stage: one-entry pending register, commit/PC/retire logic and GPR file.
// Define WBREG_BYPASS_EN to forward the pending write onto matching read ports.
module wb_regfile_pipe
  import wb_regfile_pkg::*;
#(
  parameter int          NREGS     = 16,
  parameter int          NRP       = 2,
  parameter int          DW        = DATA_W,
  parameter int          PIPELINED = 1,
  parameter logic [DW-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_W-1:0]     wb_waddr,
  input  logic [DW-1:0]             wb_wdata,
  input  logic [DW-1:0]             wb_next_pc,
  input  logic [TAG_W-1:0]          wb_tag,
  input  logic                      commit_hold,
  input  logic [NRP*REG_ADDR_W-1:0] raddr,
  output logic [NRP*DW-1:0]         rdata,
  output logic [DW-1:0]             pc,
  output logic                      pend_valid,
  output logic                      pend_wen,
  output logic [REG_ADDR_W-1:0]     pend_waddr,
  output logic [DW-1:0]             pend_wdata,
  output logic [TAG_W-1:0]          pend_tag,
  output logic                      commit_valid,
  output logic [TAG_W-1:0]          commit_tag,
  output logic [63:0]               retired_cnt
);

  logic             r_pv;
  pend_entry_t      r_pend;
  logic [DW-1:0]    r_pc;
  logic             r_cv;
  logic [TAG_W-1:0] r_ctag;
  logic [63:0]      r_cnt;

  logic              w_ready;
  logic              w_accept;
  logic              w_cmt;
  logic [NRP*DW-1:0] w_rf_rdata;

  // Ready never looks at wb_valid, so the LSU can use it without a comb loop.
  assign w_ready  = !r_pv || ((PIPELINED != 0) && !commit_hold);
  assign w_accept = wb_valid && w_ready;
  assign w_cmt    = r_pv && !commit_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv   <= 1'b0;
      r_pend <= '0;
      r_pc   <= RESET_PC;
      r_cv   <= 1'b0;
      r_ctag <= '0;
      r_cnt  <= '0;
    end else begin
      r_pv <= w_accept || (r_pv && !w_cmt);
      r_cv <= w_cmt;
      if (w_accept)
        r_pend <= '{wen: wb_wen, waddr: wb_waddr, wdata: wb_wdata,
                    next_pc: wb_next_pc, tag: wb_tag};
      if (w_cmt) begin
        r_pc   <= r_pend.next_pc;
        r_ctag <= r_pend.tag;
        r_cnt  <= r_cnt + 64'd1;
      end
    end
  end

  wb_regfile_array #(.NREGS(NREGS), .NRP(NRP), .DW(DW)) u_array (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_cmt && r_pend.wen),
    .i_waddr (r_pend.waddr),
    .i_wdata (r_pend.wdata),
    .i_raddr (raddr),
    .o_rdata (w_rf_rdata)
  );

`ifdef WBREG_BYPASS_EN
  logic [REG_ADDR_W-1:0] w_pidx;
  assign w_pidx = reg_index(r_pend.waddr, NREGS);

  always_comb begin
    rdata = w_rf_rdata;
    for (int p = 0; p < NRP; p++)
      if (r_pv && r_pend.wen && (w_pidx != '0) &&
          (reg_index(raddr[p*REG_ADDR_W +: REG_ADDR_W], NREGS) == w_pidx))
        rdata[p*DW +: DW] = r_pend.wdata;
  end
`else
  assign rdata = w_rf_rdata;
`endif

  assign wb_ready     = w_ready;
  assign pc           = r_pc;
  assign pend_valid   = r_pv;
  assign pend_wen     = r_pend.wen;
  assign pend_waddr   = r_pend.waddr;
  assign pend_wdata   = r_pend.wdata;
  assign pend_tag     = r_pend.tag;
  assign commit_valid = r_cv;
  assign commit_tag   = r_ctag;
  assign retired_cnt  = r_cnt;

endmodule

// File: tb/tb_wb_regfile_pipe.sv
// Directed bench for wb_regfile_pipe: a pipelined and a non-pipelined instance
// share inputs; each scenario only checks the instance it targets.
module tb_wb_regfile_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, wb_wen = 1'b0, commit_hold = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0, wb_next_pc = '0;
  logic [63:0] wb_tag = '0;
  logic [9:0]  raddr = '0;

  logic        wb_ready, pend_valid, pend_wen, commit_valid;
  logic [63:0] rdata;
  logic [31:0] pc, pend_wdata;
  logic [4:0]  pend_waddr;
  logic [63:0] pend_tag, commit_tag, retired_cnt;

  logic        wb_ready0, pend_valid0, pend_wen0, commit_valid0;
  logic [63:0] rdata0;
  logic [31:0] pc0, pend_wdata0;
  logic [4:0]  pend_waddr0;
  logic [63:0] pend_tag0, commit_tag0, retired_cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  wb_regfile_pipe #(.PIPELINED(1)) u_dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_next_pc(wb_next_pc), .wb_tag(wb_tag), .commit_hold(commit_hold),
    .raddr(raddr), .rdata(rdata), .pc(pc), .pend_valid(pend_valid),
    .pend_wen(pend_wen), .pend_waddr(pend_waddr), .pend_wdata(pend_wdata),
    .pend_tag(pend_tag), .commit_valid(commit_valid), .commit_tag(commit_tag),
    .retired_cnt(retired_cnt)
  );

  wb_regfile_pipe #(.PIPELINED(0)) u_dut0 (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready0),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_next_pc(wb_next_pc), .wb_tag(wb_tag), .commit_hold(commit_hold),
    .raddr(raddr), .rdata(rdata0), .pc(pc0), .pend_valid(pend_valid0),
    .pend_wen(pend_wen0), .pend_waddr(pend_waddr0), .pend_wdata(pend_wdata0),
    .pend_tag(pend_tag0), .commit_valid(commit_valid0), .commit_tag(commit_tag0),
    .retired_cnt(retired_cnt0)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] next_pc;
    logic [63:0] tag;
    logic [4:0]  ra0;
    logic [31:0] exp0;
    logic [4:0]  ra1;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] npc, input logic [63:0] tag);
    wb_valid = 1'b1; wb_wen = wen; wb_waddr = wa; wb_wdata = wd;
    wb_next_pc = npc; wb_tag = tag;
  endtask

  logic [31:0] held_exp;

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 32'h3000_0004, 64'd7,  5'd5,  32'hDEAD_BEEF, 5'd17, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 32'h3000_0008, 64'd8,  5'd0,  32'h0,         5'd5,  32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd17, 32'h0000_00AA, 32'h3000_000C, 64'd9,  5'd1,  32'hAA,        5'd16, 32'h0};
    vecs[3] = '{1'b0, 5'd6,  32'h0000_FFFF, 32'h3000_0010, 64'd10, 5'd6,  32'h0,         5'd22, 32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'h0000_0077, 32'h3000_0014, 64'd11, 5'd15, 32'h77,        5'd1,  32'hAA};
    vecs[5] = '{1'b1, 5'd21, 32'h0000_0011, 32'h3000_0018, 64'd12, 5'd5,  32'h11,        5'd21, 32'h11};
    vecs[6] = '{1'b1, 5'd3,  32'h0000_0033, 32'h3000_001C, 64'd13, 5'd3,  32'h33,        5'd19, 32'h33};

    // Reset values
    raddr = {5'd17, 5'd5};
    repeat (2) @(negedge clock);
    #1;
    chk("rst_pc", pc, 32'h3000_0000);
    chk("rst_ready", wb_ready, 1);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_pv", pend_valid, 0);
    chk("rst_cv", commit_valid, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single-instruction vectors: accept, then commit one edge later
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].next_pc, vecs[i].tag);
      raddr = {vecs[i].ra1, vecs[i].ra0};
      step();
      wb_valid = 1'b0;
      chk($sformatf("v%0d_pv", i), pend_valid, 1);
      chk($sformatf("v%0d_ptag", i), pend_tag, vecs[i].tag);
      chk($sformatf("v%0d_cv_pre", i), commit_valid, 0);
      step();
      chk($sformatf("v%0d_rd0", i), rdata[31:0], vecs[i].exp0);
      chk($sformatf("v%0d_rd1", i), rdata[63:32], vecs[i].exp1);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].next_pc);
      chk($sformatf("v%0d_cv", i), commit_valid, 1);
      chk($sformatf("v%0d_ctag", i), commit_tag, vecs[i].tag);
    end
    chk("vec_cnt", retired_cnt, 7);

    // Back-to-back stream of four, pipelined: one commit per cycle
    drive(1'b1, 5'd10, 32'h100, 32'h3000_0100, 64'd20);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) chk($sformatf("b2b_ready%0d", c), wb_ready, 1);
      step();
      chk($sformatf("b2b_cv%0d", c), commit_valid, (c >= 1 && c <= 4) ? 1 : 0);
      if (c >= 1 && c <= 4) chk($sformatf("b2b_ctag%0d", c), commit_tag, 64'd20 + 64'(c - 1));
      if (c < 3) drive(1'b1, 5'(11 + c), 32'(32'h101 + c), 32'(32'h3000_0104 + 4 * c), 64'(21 + c));
      else wb_valid = 1'b0;
    end
    raddr = {5'd10, 5'd13};
    #1;
    chk("b2b_rd0", rdata[31:0], 32'h103);
    chk("b2b_rd1", rdata[63:32], 32'h100);
    chk("b2b_pc", pc, 32'h3000_010C);
    chk("b2b_cnt", retired_cnt, 11);

    // Commit hold on a pending write to x3 (old value 0x33)
`ifdef WBREG_BYPASS_EN
    held_exp = 32'h99;
`else
    held_exp = 32'h33;
`endif
    commit_hold = 1'b1;
    drive(1'b1, 5'd3, 32'h99, 32'h3000_0200, 64'd30);
    raddr = {5'd0, 5'd3};
    step();
    wb_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk($sformatf("hold_ready%0d", h), wb_ready, 0);
      chk($sformatf("hold_pv%0d", h), pend_valid, 1);
      chk($sformatf("hold_pc%0d", h), pc, 32'h3000_010C);
      chk($sformatf("hold_cv%0d", h), commit_valid, 0);
      chk($sformatf("hold_rd%0d", h), rdata[31:0], held_exp);
      step();
    end
    commit_hold = 1'b0;
    #1;
    chk("rel_ready", wb_ready, 1);
    step();
    chk("rel_cv", commit_valid, 1);
    chk("rel_ctag", commit_tag, 30);
    chk("rel_rd", rdata[31:0], 32'h99);
    chk("rel_pc", pc, 32'h3000_0200);
    chk("rel_cnt", retired_cnt, 12);
    step();
    chk("rel_cv_once", commit_valid, 0);
    chk("rel_cnt_once", retired_cnt, 12);

    // Reset while an entry is pending: it must never be written
    drive(1'b1, 5'd9, 32'h55, 32'h3000_0300, 64'd40);
    raddr = {5'd0, 5'd9};
    step();
    wb_valid = 1'b0;
    chk("mrst_pv_before", pend_valid, 1);
    reset = 1'b1;
    #1;
    chk("mrst_pv", pend_valid, 0);
    chk("mrst_pc", pc, 32'h3000_0000);
    chk("mrst_cnt", retired_cnt, 0);
    step();
    reset = 1'b0;
    step();
    chk("mrst_rd9", rdata[31:0], 32'h0);
    chk("mrst_cv", commit_valid, 0);
    chk("mrst_pc_after", pc, 32'h3000_0000);

    // Non-pipelined instance: ready alternates, four retires take eight cycles
    drive(1'b1, 5'd2, 32'h200, 32'h3000_0400, 64'd50);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("np_ready%0d", c), wb_ready0, (c % 2 == 0) ? 1 : 0);
      step();
      chk($sformatf("np_cv%0d", c), commit_valid0, (c % 2 == 1) ? 1 : 0);
      if (c % 2 == 1) chk($sformatf("np_ctag%0d", c), commit_tag0, 64'd50 + 64'(c / 2));
      if (c % 2 == 0) begin
        if (c < 6) drive(1'b1, 5'(3 + c / 2), 32'(32'h201 + c / 2),
                         32'(32'h3000_0404 + 2 * c), 64'(51 + c / 2));
        else wb_valid = 1'b0;
      end
    end
    raddr = {5'd2, 5'd5};
    #1;
    chk("np_cnt", retired_cnt0, 4);
    chk("np_pc", pc0, 32'h3000_040C);
    chk("np_rd0", rdata0[31:0], 32'h203);
    chk("np_rd1", rdata0[63:32], 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
